// File: rtl/frequency_meter.sv
// Frequency meter for an asynchronous square-wave tone.
//
// The input passes through a two-flop synchronizer and a stability filter.
// The period between rising edges of the filtered level is then measured in
// clock cycles and averaged over 2^AVG_LOG2 consecutive periods. If no rising
// edge arrives within TIMEOUT_CYCLES, the measurement is abandoned and
// no_signal is raised.
//
// Parameters:
//   CLOCK_FREQUENCY  clock rate in Hz; only used to derive the default timeout
//   FILTER_CYCLES    consecutive stable cycles needed to accept a level change
//   AVG_LOG2         log2 of the number of periods averaged per result
//   TIMEOUT_CYCLES   longest measurable period in cycles (< 2^PERIOD_WIDTH)
//   PERIOD_WIDTH     width of the period result
//
// Ports:
//   clock         single clock, rising edge
//   reset         synchronous, active-high reset
//   in            asynchronous tone input
//   period        averaged input period in clock cycles
//   period_valid  one-cycle pulse when period is updated
//   no_signal     high while no valid measurement exists
module frequency_meter #(
    parameter int unsigned CLOCK_FREQUENCY = 12000000,
    parameter int unsigned FILTER_CYCLES   = 16,
    parameter int unsigned AVG_LOG2        = 2,
    parameter int unsigned TIMEOUT_CYCLES  = CLOCK_FREQUENCY / 10,
    parameter int unsigned PERIOD_WIDTH    = 24
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    no_signal
);

    localparam int unsigned FiltW = $clog2(FILTER_CYCLES + 1);
    // Sum of 2^AVG_LOG2 periods, each below 2^PERIOD_WIDTH, cannot overflow.
    localparam int unsigned AccW  = PERIOD_WIDTH + AVG_LOG2;
    localparam int unsigned NW    = AVG_LOG2 + 1;

    localparam logic [FiltW-1:0]        FiltLast = FiltW'(FILTER_CYCLES - 1);
    localparam logic [NW-1:0]           NLast    = NW'((1 << AVG_LOG2) - 1);
    localparam logic [PERIOD_WIDTH-1:0] Timeout  = PERIOD_WIDTH'(TIMEOUT_CYCLES);

    typedef enum logic [0:0] {
        StWaitFirst,
        StMeasure
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic sync1;
    logic sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Stability filter and rising-edge detect
    // ------------------------------------------------------------------
    logic             in_f;
    logic [FiltW-1:0] stab_cnt;
    logic             rise;

    always_ff @(posedge clock) begin
        if (reset) begin
            in_f     <= 1'b0;
            stab_cnt <= '0;
            rise     <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync2 != in_f) begin
                if (stab_cnt == FiltLast) begin
                    // The new level has now been seen for FILTER_CYCLES cycles.
                    in_f     <= sync2;
                    stab_cnt <= '0;
                    rise     <= sync2;
                end else begin
                    stab_cnt <= stab_cnt + FiltW'(1);
                end
            end else begin
                // Any return to the accepted level restarts the count.
                stab_cnt <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Period measurement FSM
    // ------------------------------------------------------------------
    state_t                  state;
    logic [PERIOD_WIDTH-1:0] cnt;
    logic [AccW-1:0]         acc;
    logic [NW-1:0]           n;
    logic [AccW-1:0]         total;

    // Running total including the period that ends at this rise.
    always_comb begin
        total = acc + AccW'(cnt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= StWaitFirst;
            cnt          <= '0;
            acc          <= '0;
            n            <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            no_signal    <= 1'b1;
        end else begin
            period_valid <= 1'b0;
            case (state)
                StWaitFirst: begin
                    if (rise) begin
                        state <= StMeasure;
                        cnt   <= PERIOD_WIDTH'(1);
                        acc   <= '0;
                        n     <= '0;
                    end
                end
                StMeasure: begin
                    if (rise) begin
                        // A rise on the timeout cycle still counts normally.
                        cnt <= PERIOD_WIDTH'(1);
                        if (n == NLast) begin
                            period       <= total[AVG_LOG2 +: PERIOD_WIDTH];
                            period_valid <= 1'b1;
                            no_signal    <= 1'b0;
                            acc          <= '0;
                            n            <= '0;
                        end else begin
                            acc <= total;
                            n   <= n + NW'(1);
                        end
                    end else if (cnt == Timeout) begin
                        state     <= StWaitFirst;
                        cnt       <= '0;
                        acc       <= '0;
                        n         <= '0;
                        period    <= '0;
                        no_signal <= 1'b1;
                    end else begin
                        cnt <= cnt + PERIOD_WIDTH'(1);
                    end
                end
                default: begin
                    state <= StWaitFirst;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frequency_meter.sv
// Directed testbench for frequency_meter.
//
// Tone periods are scaled down (1834 cycles instead of 45866) and the timeout
// is shortened to 2500 cycles so the whole run stays short; the filter and
// averaging parameters keep their defaults.
module tb_frequency_meter;

    localparam int unsigned Filter  = 16;
    localparam int unsigned AvgLog2 = 2;
    localparam int unsigned Timeout = 2500;
    localparam int unsigned Pw      = 24;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in    = 1'b0;
    logic [Pw-1:0] period;
    logic          period_valid;
    logic          no_signal;

    frequency_meter #(
        .CLOCK_FREQUENCY(12000000),
        .FILTER_CYCLES  (Filter),
        .AVG_LOG2       (AvgLog2),
        .TIMEOUT_CYCLES (Timeout),
        .PERIOD_WIDTH   (Pw)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in          (in),
        .period      (period),
        .period_valid(period_valid),
        .no_signal   (no_signal)
    );

    always #5 clock = ~clock;

    int            n_checks    = 0;
    int            n_fail      = 0;
    int            cyc         = 0;
    int            valid_count = 0;
    logic [Pw-1:0] last_period = '0;
    logic          prev_valid  = 1'b0;
    int            last_rise_k = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: counts result pulses and checks they are never back to back.
    always @(posedge clock) begin
        cyc++;
        #1;
        if (period_valid === 1'b1) begin
            check_eq("valid_gap", 32'(prev_valid), 32'd0);
            valid_count++;
            last_period = period;
        end
        prev_valid = period_valid;
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic do_reset(input int cycles);
        reset = 1'b1;
        in    = 1'b0;
        repeat (cycles) @(negedge clock);
        check_eq("reset_period", 32'(period), 32'd0);
        check_eq("reset_valid", 32'(period_valid), 32'd0);
        check_eq("reset_no_signal", 32'(no_signal), 32'd1);
        reset = 1'b0;
    endtask

    task automatic wave(input int h, input int l);
        in          = 1'b1;
        last_rise_k = cyc + 1;
        repeat (h) @(negedge clock);
        in = 1'b0;
        repeat (l) @(negedge clock);
    endtask

    task automatic wave_glitch(input int h, input int l1, input int g, input int l2);
        in          = 1'b1;
        last_rise_k = cyc + 1;
        repeat (h) @(negedge clock);
        in = 1'b0;
        repeat (l1) @(negedge clock);
        in = 1'b1;
        repeat (g) @(negedge clock);
        in = 1'b0;
        repeat (l2) @(negedge clock);
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int w;
        int per [13];

        @(negedge clock);
        do_reset(3);

        // Steady tone: one result after first rise + 4 periods, then every 4.
        base = valid_count;
        for (int i = 0; i < 5; i++) wave(917, 917);
        check_eq("tone_count1", 32'(valid_count - base), 32'd1);
        check_eq("tone_period1", 32'(last_period), 32'd1834);
        check_eq("tone_no_signal", 32'(no_signal), 32'd0);
        for (int i = 0; i < 4; i++) wave(917, 917);
        check_eq("tone_count2", 32'(valid_count - base), 32'd2);
        check_eq("tone_period2", 32'(last_period), 32'd1834);

        // Alternating 1000/1002 averages to 1001; then 4001/4 truncates to 1000.
        do_reset(2);
        base = valid_count;
        per = '{1000, 1002, 1000, 1002, 1000, 1002, 1000, 1002,
                1000, 1000, 1000, 1001, 1000};
        for (int i = 0; i < 13; i++) begin
            wave(500, per[i] - 500);
            if (i == 4) begin
                check_eq("alt_count1", 32'(valid_count - base), 32'd1);
                check_eq("alt_period1", 32'(last_period), 32'd1001);
            end
            if (i == 8) begin
                check_eq("alt_count2", 32'(valid_count - base), 32'd2);
                check_eq("alt_period2", 32'(last_period), 32'd1001);
            end
            if (i == 12) begin
                check_eq("trunc_count", 32'(valid_count - base), 32'd3);
                check_eq("trunc_period", 32'(last_period), 32'd1000);
            end
        end

        // 5-cycle glitches in the low phase are rejected by the filter.
        do_reset(2);
        base = valid_count;
        for (int i = 0; i < 5; i++) wave_glitch(917, 400, 5, 512);
        check_eq("glitch_count1", 32'(valid_count - base), 32'd1);
        check_eq("glitch_period1", 32'(last_period), 32'd1834);
        for (int i = 0; i < 4; i++) wave_glitch(917, 400, 5, 512);
        check_eq("glitch_count2", 32'(valid_count - base), 32'd2);
        check_eq("glitch_period2", 32'(last_period), 32'd1834);

        // Input stops: timeout lands Timeout cycles after the last counted rise,
        // which itself trails the in edge by Filter + 2 cycles.
        w = 0;
        while (no_signal !== 1'b1 && w < int'(Timeout) + 200) begin
            @(negedge clock);
            w++;
        end
        check_eq("timeout_seen", 32'(no_signal), 32'd1);
        check_eq("timeout_delay", 32'(cyc - last_rise_k), 32'(Filter + 2 + Timeout));
        check_eq("timeout_period", 32'(period), 32'd0);
        check_eq("timeout_no_pulse", 32'(valid_count - base), 32'd2);

        // Restart needs the first rise plus 4 full periods.
        base = valid_count;
        for (int i = 0; i < 4; i++) wave(500, 500);
        check_eq("restart_early", 32'(valid_count - base), 32'd0);
        wave(500, 500);
        check_eq("restart_count", 32'(valid_count - base), 32'd1);
        check_eq("restart_period", 32'(last_period), 32'd1000);
        check_eq("restart_no_signal", 32'(no_signal), 32'd0);

        // Single-cycle reset mid-measurement discards the partial average.
        do_reset(2);
        base = valid_count;
        for (int i = 0; i < 3; i++) wave(500, 500);
        do_reset(1);
        for (int i = 0; i < 4; i++) wave(500, 500);
        check_eq("midreset_early", 32'(valid_count - base), 32'd0);
        wave(500, 500);
        check_eq("midreset_count", 32'(valid_count - base), 32'd1);
        check_eq("midreset_period", 32'(last_period), 32'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
